// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the byte-wide instruction memory sequencer.
package imem_ctrl_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned CNT_W          = 3;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        RESP
    } state_t;

    // Response payload presented to the fetch stage
    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic              err;
    } fetch_rsp_t;

    // Big-endian assembly: earlier bytes end up in the upper lanes
    function automatic logic [WORD_W-1:0] shift_in_byte(input logic [WORD_W-1:0] w,
                                                        input logic [BYTE_W-1:0] b);
        return {w[WORD_W-BYTE_W-1:0], b};
    endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Fetch, loader and memory-port signals of the instruction memory sequencer.
interface imem_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  fetch_req;
    logic [31:0]           fetch_addr;
    logic                  fetch_flush;
    logic                  fetch_ready;
    logic                  fetch_valid;
    logic [31:0]           fetch_rdata;
    logic                  fetch_err;

    logic                  ld_valid;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [7:0]            ld_data;
    logic                  ld_ready;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;

    // Environment side: fetch stage, program loader and the memory array
    modport master (
        output fetch_req, fetch_addr, fetch_flush,
        input  fetch_ready, fetch_valid, fetch_rdata, fetch_err,
        output ld_valid, ld_addr, ld_data,
        input  ld_ready,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_flush,
        output fetch_ready, fetch_valid, fetch_rdata, fetch_err,
        input  ld_valid, ld_addr, ld_data,
        output ld_ready,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/imem_line_buf.sv
// One-entry fetched-word buffer: tag compare, fill on read completion, invalidate on writes.
module imem_line_buf
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inval,
    input  logic                  fill,
    input  logic [ADDR_WIDTH-1:0] fill_tag,
    input  logic [WORD_W-1:0]     fill_word,
    input  logic [ADDR_WIDTH-1:0] lookup_tag,
    output logic                  hit_c,
    output logic [WORD_W-1:0]     word
);
    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word    <= '0;
        end else if (inval) begin
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag;
            word    <= fill_word;
        end
    end

    assign hit_c = valid_q && (tag_q == lookup_tag);

endmodule

// File: rtl/imem_ctrl.sv
// Fetch/loader arbiter and 4-byte serial word reader for the byte-wide instruction memory.
// Optional one-entry word buffer enabled by defining IMEM_LINE_BUF_EN.
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_WIDTH = 12,
    parameter logic [WORD_W-1:0] NOP_INSTR  = NOP_INSTR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    imem_ctrl_if.slave bus
);
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [WORD_W-1:0]     shreg_q, shreg_d;
    fetch_rsp_t            rsp_q, rsp_d;
    logic                  valid_q;

    logic [ADDR_WIDTH-1:0] req_base;
    logic [WORD_W-1:0]     word_c;
    logic                  buf_hit_c;
    logic [WORD_W-1:0]     buf_word;
    logic                  buf_fill;
    logic                  buf_inval;
    logic                  unused_addr_hi;

    assign req_base       = bus.fetch_addr[ADDR_WIDTH-1:0];
    assign word_c         = shift_in_byte(shreg_q, bus.mem_rdata);
    assign unused_addr_hi = ^bus.fetch_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            shreg_q <= '0;
            rsp_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            shreg_q <= shreg_d;
            rsp_q   <= rsp_d;
            valid_q <= (state_d == RESP);
        end
    end

    // Next state, port arbitration and byte assembly
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        base_d          = base_q;
        shreg_d         = shreg_q;
        rsp_d           = rsp_q;
        bus.fetch_ready = 1'b0;
        bus.ld_ready    = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        buf_fill        = 1'b0;
        buf_inval       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ld_valid) begin
                    bus.ld_ready  = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = bus.ld_addr;
                    bus.mem_wdata = bus.ld_data;
                    buf_inval     = 1'b1;
                end else begin
                    bus.fetch_ready = 1'b1;
                    if (bus.fetch_req) begin
                        base_d = req_base;
                        if (bus.fetch_addr[1:0] != 2'b00) begin
                            state_d = RESP;
                            rsp_d   = '{word: NOP_INSTR, err: 1'b1};
                        end else if (buf_hit_c) begin
                            state_d = RESP;
                            rsp_d   = '{word: buf_word, err: 1'b0};
                        end else begin
                            state_d = RD;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            RD: begin
                if (cnt_q < CNT_W'(BYTES_PER_WORD)) begin
                    bus.mem_addr = base_q + ADDR_WIDTH'(cnt_q);
                end
                if (bus.fetch_flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    // Read data lags the address by one cycle, so byte cnt-1 arrives now
                    if (cnt_q != '0) begin
                        shreg_d = word_c;
                    end
                    if (cnt_q == CNT_W'(BYTES_PER_WORD)) begin
                        state_d  = RESP;
                        cnt_d    = '0;
                        rsp_d    = '{word: word_c, err: 1'b0};
                        buf_fill = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.fetch_valid = valid_q;
    assign bus.fetch_rdata = rsp_q.word;
    assign bus.fetch_err   = rsp_q.err;

`ifdef IMEM_LINE_BUF_EN
    imem_line_buf #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .inval      (buf_inval),
        .fill       (buf_fill),
        .fill_tag   (base_q),
        .fill_word  (word_c),
        .lookup_tag (req_base),
        .hit_c      (buf_hit_c),
        .word       (buf_word)
    );
`else
    logic unused_buf;
    assign buf_hit_c  = 1'b0;
    assign buf_word   = '0;
    assign unused_buf = ^{buf_fill, buf_inval};
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// Scoreboard bench for imem_ctrl: sync-read byte memory model plus expected-response queue.
module tb_imem_ctrl;
    import imem_ctrl_pkg::*;

    localparam int unsigned AW = 12;
`ifdef IMEM_LINE_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    imem_ctrl #(
        .ADDR_WIDTH(AW),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    logic [7:0]    model_mem [4096];
    logic          buf_v;
    logic [AW-1:0] buf_tag;
    logic [AW-1:0] addr_seen [4];
    logic          we_seen;
    logic          ld_ready_seen;

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            'h100:   return 8'h00;
            'h101:   return 8'h50;
            'h102:   return 8'h00;
            'h103:   return 8'h93;
            default: return 8'(a * 7 + 3);
        endcase
    endfunction

    // Synchronous-read byte memory, preloaded on the first clock
    logic [7:0] mem [4096];
    logic       loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_byte(i);
            loaded <= 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    function automatic logic [31:0] model_word(input logic [AW-1:0] b);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w = {w[23:0], model_mem[AW'(b + AW'(i))]};
        return w;
    endfunction

    // Drive a fetch at a negedge; it is accepted on the next posedge
    task automatic issue_fetch(input logic [31:0] a, input bit track);
        exp_t          e;
        logic [AW-1:0] b;
        b = a[AW-1:0];
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        if (track) begin
            if (a[1:0] != 2'b00) begin
                e = '{32'h0000_0013, 1'b1, 1};
            end else if (BUF_EN && buf_v && buf_tag == b) begin
                e = '{model_word(b), 1'b0, 1};
            end else begin
                e = '{model_word(b), 1'b0, 6};
                buf_v   = 1'b1;
                buf_tag = b;
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.fetch_req = 1'b0;
    endtask

    // Wait (bounded) for fetch_valid, recording the memory port along the way
    task automatic wait_valid(output int lat);
        we_seen       = 1'b0;
        ld_ready_seen = 1'b0;
        for (lat = 1; lat < 12; lat++) begin
            if (lat <= 4) addr_seen[lat-1] = bus.mem_addr;
            we_seen       = we_seen | bus.mem_we;
            ld_ready_seen = ld_ready_seen | bus.ld_ready;
            if (bus.fetch_valid === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic ld_write(input logic [AW-1:0] a, input logic [7:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        model_mem[a] = d;
        buf_v        = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (bus.fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.fetch_valid); end
        total++; if (bus.fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", bus.fetch_err); end
        total++; if (bus.fetch_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.fetch_rdata); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", bus.mem_we); end
        total++; if (bus.mem_addr !== 12'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", bus.mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.fetch_ready); end
        @(negedge clk);
    endtask

    task automatic test_aligned_fetch();
        exp_t e;
        int   lat;
        issue_fetch(32'h100, 1'b1);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (lat != e.lat) begin bad++; $display("FAIL t1_latency got=%0d want=%0d", lat, e.lat); end
        total++; if (bus.fetch_rdata !== 32'h0050_0093) begin bad++; $display("FAIL t1_rdata got=%h want=00500093", bus.fetch_rdata); end
        total++; if (bus.fetch_rdata !== e.rdata) begin bad++; $display("FAIL t1_rdata_sb got=%h want=%h", bus.fetch_rdata, e.rdata); end
        total++; if (bus.fetch_err !== e.err) begin bad++; $display("FAIL t1_err got=%b want=%b", bus.fetch_err, e.err); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (addr_seen[i] !== AW'(12'h100 + i)) begin
                bad++; $display("FAIL t1_addr%0d got=%h want=%h", i, addr_seen[i], AW'(12'h100 + i));
            end
        end
        total++; if (we_seen !== 1'b0) begin bad++; $display("FAIL t1_we got=%b want=0", we_seen); end
        @(negedge clk);
        total++; if (bus.fetch_valid !== 1'b0) begin bad++; $display("FAIL t1_pulse got=%b want=0", bus.fetch_valid); end
    endtask

    task automatic test_misaligned();
        exp_t e;
        int   lat;
        issue_fetch(32'h102, 1'b1);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (lat != e.lat) begin bad++; $display("FAIL t2_latency got=%0d want=%0d", lat, e.lat); end
        total++; if (bus.fetch_rdata !== e.rdata) begin bad++; $display("FAIL t2_rdata got=%h want=%h", bus.fetch_rdata, e.rdata); end
        total++; if (bus.fetch_err !== 1'b1) begin bad++; $display("FAIL t2_err got=%b want=1", bus.fetch_err); end
        total++; if (we_seen !== 1'b0) begin bad++; $display("FAIL t2_we got=%b want=0", we_seen); end
        @(negedge clk);
    endtask

    task automatic test_addr_boundary();
        exp_t e;
        int   lat;
        // Top of the 4 KiB space
        issue_fetch(32'hFFC, 1'b1);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (lat != e.lat) begin bad++; $display("FAIL t3_latency got=%0d want=%0d", lat, e.lat); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (addr_seen[i] !== AW'(12'hFFC + i)) begin
                bad++; $display("FAIL t3_addr%0d got=%h want=%h", i, addr_seen[i], AW'(12'hFFC + i));
            end
        end
        total++; if (bus.fetch_rdata !== e.rdata) begin bad++; $display("FAIL t3_rdata got=%h want=%h", bus.fetch_rdata, e.rdata); end
        @(negedge clk);
        // Upper address bits are dropped: 0x1000 aliases 0x000
        issue_fetch(32'h1000, 1'b1);
        wait_valid(lat);
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (addr_seen[i] !== AW'(i)) begin
                bad++; $display("FAIL t3_alias_addr%0d got=%h want=%h", i, addr_seen[i], AW'(i));
            end
        end
        total++; if (bus.fetch_rdata !== e.rdata) begin bad++; $display("FAIL t3_alias_rdata got=%h want=%h", bus.fetch_rdata, e.rdata); end
        @(negedge clk);
        issue_fetch(32'hFFE, 1'b1);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (lat != e.lat) begin bad++; $display("FAIL t3_ffe_latency got=%0d want=%0d", lat, e.lat); end
        total++; if (bus.fetch_err !== 1'b1) begin bad++; $display("FAIL t3_ffe_err got=%b want=1", bus.fetch_err); end
        total++; if (bus.fetch_rdata !== e.rdata) begin bad++; $display("FAIL t3_ffe_rdata got=%h want=%h", bus.fetch_rdata, e.rdata); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic saw;
        issue_fetch(32'h100, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.fetch_flush = 1'b1;
        @(negedge clk);
        bus.fetch_flush = 1'b0;
        #1;
        total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL t4_ready got=%b want=1", bus.fetch_ready); end
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            saw = saw | bus.fetch_valid;
            @(negedge clk);
        end
        total++; if (saw !== 1'b0) begin bad++; $display("FAIL t4_no_valid got=%b want=0", saw); end
    endtask

    task automatic test_loader();
        exp_t e;
        int   lat;
        bus.ld_valid   = 1'b1;
        bus.ld_addr    = 12'h200;
        bus.ld_data    = 8'hAB;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h200;
        #1;
        total++; if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL t5_ld_ready got=%b want=1", bus.ld_ready); end
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL t5_we got=%b want=1", bus.mem_we); end
        total++; if (bus.mem_addr !== 12'h200) begin bad++; $display("FAIL t5_addr got=%h want=200", bus.mem_addr); end
        total++; if (bus.mem_wdata !== 8'hAB) begin bad++; $display("FAIL t5_wdata got=%h want=ab", bus.mem_wdata); end
        total++; if (bus.fetch_ready !== 1'b0) begin bad++; $display("FAIL t5_fetch_blocked got=%b want=0", bus.fetch_ready); end
        model_mem[12'h200] = 8'hAB;
        buf_v = 1'b0;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        #1;
        total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL t5_retry_ready got=%b want=1", bus.fetch_ready); end
        issue_fetch(32'h200, 1'b1);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (lat != e.lat) begin bad++; $display("FAIL t5_latency got=%0d want=%0d", lat, e.lat); end
        total++; if (bus.fetch_rdata !== e.rdata) begin bad++; $display("FAIL t5_rdata got=%h want=%h", bus.fetch_rdata, e.rdata); end
        @(negedge clk);
        // Loader arriving mid-read must wait for IDLE
        issue_fetch(32'h100, 1'b1);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 12'h300;
        bus.ld_data  = 8'h5C;
        #1;
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (ld_ready_seen !== 1'b0) begin bad++; $display("FAIL t5_ld_wait got=%b want=0", ld_ready_seen); end
        total++; if (we_seen !== 1'b0) begin bad++; $display("FAIL t5_rd_we got=%b want=0", we_seen); end
        total++; if (bus.fetch_rdata !== e.rdata) begin bad++; $display("FAIL t5_rd_rdata got=%h want=%h", bus.fetch_rdata, e.rdata); end
        @(negedge clk);
        #1;
        total++; if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL t5_ld_late got=%b want=1", bus.ld_ready); end
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL t5_we_late got=%b want=1", bus.mem_we); end
        model_mem[12'h300] = 8'h5C;
        buf_v = 1'b0;
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) ld_write(12'h180, 8'h77);
            issue_fetch(32'h100, 1'b1);
            wait_valid(lat);
            e = exp_q.pop_front();
            total++; if (lat != e.lat) begin bad++; $display("FAIL t6_latency%0d got=%0d want=%0d", k, lat, e.lat); end
            total++; if (bus.fetch_rdata !== e.rdata) begin bad++; $display("FAIL t6_rdata%0d got=%h want=%h", k, bus.fetch_rdata, e.rdata); end
            total++; if (bus.fetch_err !== 1'b0) begin bad++; $display("FAIL t6_err%0d got=%b want=0", k, bus.fetch_err); end
            @(negedge clk);
        end
        // Reading back the loader-written byte at 0x300
        issue_fetch(32'h300, 1'b1);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (bus.fetch_rdata[31:24] !== 8'h5C) begin bad++; $display("FAIL t6_ld_byte got=%h want=5c", bus.fetch_rdata[31:24]); end
        total++; if (bus.fetch_rdata !== e.rdata) begin bad++; $display("FAIL t6_ld_word got=%h want=%h", bus.fetch_rdata, e.rdata); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   lat;
        logic saw;
        issue_fetch(32'h104, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (bus.fetch_valid !== 1'b0) begin bad++; $display("FAIL t7_valid got=%b want=0", bus.fetch_valid); end
        total++; if (bus.mem_addr !== 12'h0) begin bad++; $display("FAIL t7_addr got=%h want=0", bus.mem_addr); end
        @(negedge clk);
        rst   = 1'b0;
        buf_v = 1'b0;
        #1;
        total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL t7_ready got=%b want=1", bus.fetch_ready); end
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            saw = saw | bus.fetch_valid;
        end
        total++; if (saw !== 1'b0) begin bad++; $display("FAIL t7_no_valid got=%b want=0", saw); end
        issue_fetch(32'h100, 1'b1);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (lat != e.lat) begin bad++; $display("FAIL t7_latency got=%0d want=%0d", lat, e.lat); end
        total++; if (bus.fetch_rdata !== e.rdata) begin bad++; $display("FAIL t7_rdata got=%h want=%h", bus.fetch_rdata, e.rdata); end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.fetch_req   = 1'b0;
        bus.fetch_addr  = '0;
        bus.fetch_flush = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        buf_v           = 1'b0;
        buf_tag         = '0;
        for (int i = 0; i < 4096; i++) model_mem[i] = init_byte(i);
        repeat (3) @(negedge clk);

        test_reset();
        test_aligned_fetch();
        test_misaligned();
        test_addr_boundary();
        test_flush();
        test_loader();
        test_back_to_back();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
